alu_scheduler: RTL and testbench

Sequencing and sharing controller for the 8-bit `alu` datapath. Arbitrates two requesters (port 0, port 1) with round-robin valid/ready handshakes and drives the combinational `alu` instance from registered operands. It waits a configurable number of cycles for multiply/divide/remainder, then returns a registered result and flags to the winning requester. It also keeps a sticky copy of the last committed flags for the processor status register.

---
 rtl/alu_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_alu_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin sequencer that shares one combinational 8-bit
// ALU between two requesters. Operands are latched on accept, held on the
// ALU inputs for a fixed number of EXEC cycles, and the result and flags are
// returned over a per-port valid/ready response handshake. A sticky copy of
// the last committed flags is kept for the processor status register.
module alu_scheduler #(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req_a0,
  input  logic [7:0] req_b0,
  input  logic [7:0] req_a1,
  input  logic [7:0] req_b1,
  input  logic [3:0] req_op0,
  input  logic [3:0] req_op1,
  output logic [1:0] rsp_valid,
  input  logic [1:0] rsp_ready,
  output logic [7:0] rsp_resultado,
  output logic [7:0] rsp_flags,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [7:0] alu_resultado,
  input  logic [7:0] alu_flags,
  output logic [7:0] status_flags,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Last EXEC count value for multi-cycle ops (counter runs n-1 down to 0).
  localparam logic [3:0] MULDIV_LAST = 4'(MULDIV_CYCLES - 1);

  // Multiply, divide and remainder are the only multi-cycle operations.
  function automatic logic is_muldiv(input logic [3:0] op);
    logic r;
    case (op)
      4'b1000: r = 1'b1;
      4'b1001: r = 1'b1;
      4'b1010: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Initial wait counter value: cycle count of the op minus one.
  function automatic logic [3:0] exec_last(input logic [3:0] op);
    logic [3:0] r;
    if (is_muldiv(op)) begin
      r = MULDIV_LAST;
    end else begin
      r = 4'd0;
    end
    return r;
  endfunction

  // The ALU only drives carry for add/sub; bit 5 is cleared for every other op.
  function automatic logic [7:0] mask_flags(input logic [3:0] op, input logic [7:0] flags);
    logic [7:0] r;
    r = flags;
    case (op)
      4'b0000: r[5] = flags[5];
      4'b0001: r[5] = flags[5];
      default: r[5] = 1'b0;
    endcase
    return r;
  endfunction

  state_t     state_r;
  logic       grant_r;
  logic       last_grant_r;
  logic [3:0] wait_cnt_r;
  logic [7:0] a_r;
  logic [7:0] b_r;
  logic [3:0] op_r;
  logic [1:0] rsp_valid_r;
  logic       busy_r;
  logic [7:0] rsp_resultado_r;
  logic [7:0] rsp_flags_r;
  logic [7:0] status_flags_r;

  logic       sel_s;
  logic       sel_valid_s;
  logic       accept_s;
  logic [1:0] req_ready_s;
  logic [7:0] sel_a_s;
  logic [7:0] sel_b_s;
  logic [3:0] sel_op_s;

  // Round-robin pick: on a tie the requester that did not win last time goes.
  always_comb begin
    sel_s       = 1'b0;
    sel_valid_s = 1'b0;
    case (req_valid)
      2'b01: begin
        sel_s       = 1'b0;
        sel_valid_s = 1'b1;
      end
      2'b10: begin
        sel_s       = 1'b1;
        sel_valid_s = 1'b1;
      end
      2'b11: begin
        sel_s       = ~last_grant_r;
        sel_valid_s = 1'b1;
      end
      default: begin
        sel_s       = 1'b0;
        sel_valid_s = 1'b0;
      end
    endcase
  end

  // Ready is offered only in IDLE and only to the selected requester.
  always_comb begin
    req_ready_s = 2'b00;
    accept_s    = 1'b0;
    if ((state_r == ST_IDLE) && sel_valid_s) begin
      req_ready_s[sel_s] = 1'b1;
      accept_s           = 1'b1;
    end else begin
      req_ready_s = 2'b00;
      accept_s    = 1'b0;
    end
  end

  // Payload of the selected requester.
  always_comb begin
    sel_a_s  = req_a0;
    sel_b_s  = req_b0;
    sel_op_s = req_op0;
    if (sel_s) begin
      sel_a_s  = req_a1;
      sel_b_s  = req_b1;
      sel_op_s = req_op1;
    end else begin
      sel_a_s  = req_a0;
      sel_b_s  = req_b0;
      sel_op_s = req_op0;
    end
  end

  // Sequencing FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      grant_r         <= 1'b0;
      last_grant_r    <= 1'b1;
      wait_cnt_r      <= 4'd0;
      a_r             <= 8'h00;
      b_r             <= 8'h00;
      op_r            <= 4'b0000;
      rsp_valid_r     <= 2'b00;
      busy_r          <= 1'b0;
      rsp_resultado_r <= 8'h00;
      rsp_flags_r     <= 8'h00;
      status_flags_r  <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_r          <= sel_a_s;
            b_r          <= sel_b_s;
            op_r         <= sel_op_s;
            grant_r      <= sel_s;
            last_grant_r <= sel_s;
            wait_cnt_r   <= exec_last(sel_op_s);
            busy_r       <= 1'b1;
            state_r      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (wait_cnt_r == 4'd0) begin
            rsp_resultado_r <= alu_resultado;
            rsp_flags_r     <= mask_flags(op_r, alu_flags);
            status_flags_r  <= mask_flags(op_r, alu_flags);
            rsp_valid_r     <= grant_r ? 2'b10 : 2'b01;
            state_r         <= ST_RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          // Only the granted port's ready can retire the response.
          if (rsp_ready[grant_r]) begin
            rsp_valid_r <= 2'b00;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_r <= 2'b00;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_s;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_resultado = rsp_resultado_r;
  assign rsp_flags     = rsp_flags_r;
  assign status_flags  = status_flags_r;
  assign busy          = busy_r;
  assign alu_a         = a_r;
  assign alu_b         = b_r;
  assign alu_op        = op_r;

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with a small behavioural ALU attached.
module tb_alu_scheduler;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0] req_op0, req_op1;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [7:0] rsp_resultado, rsp_flags;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_op;
  logic [7:0] alu_resultado, alu_flags;
  logic [7:0] status_flags;
  logic       busy;

  int vectors_applied;
  int miscompares;

  alu_scheduler #(.MULDIV_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_resultado(rsp_resultado), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_resultado(alu_resultado), .alu_flags(alu_flags),
    .status_flags(status_flags), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: flags {N,Z,C,P,I,D,V,-}; carry is junk (1) for non add/sub.
  logic [8:0]  sum9;
  logic [15:0] prod;
  logic [7:0]  res_m;
  logic        c_m, v_m;
  always_comb begin
    sum9  = {1'b0, alu_a} + {1'b0, alu_b};
    prod  = {8'h00, alu_a} * {8'h00, alu_b};
    res_m = 8'h00;
    c_m   = 1'b1;
    v_m   = 1'b0;
    case (alu_op)
      4'b0000: begin
        res_m = sum9[7:0];
        c_m   = sum9[8];
        v_m   = (alu_a[7] == alu_b[7]) && (sum9[7] != alu_a[7]);
      end
      4'b0001: begin
        res_m = alu_a - alu_b;
        c_m   = (alu_a < alu_b);
        v_m   = (alu_a[7] != alu_b[7]) && (res_m[7] != alu_a[7]);
      end
      4'b1000: res_m = prod[7:0];
      4'b1001: res_m = (alu_b == 8'h00) ? 8'hFF : alu_a / alu_b;
      4'b1010: res_m = (alu_b == 8'h00) ? alu_a : alu_a % alu_b;
      default: res_m = 8'h00;
    endcase
    alu_resultado = res_m;
    alu_flags     = {res_m[7], (res_m == 8'h00), c_m, ^res_m, 1'b0, 1'b0, v_m, 1'b0};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_ready"}, req_ready, 2'b00);
    chk({tag, "_rsp_valid"}, rsp_valid, 2'b00);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rsp_res"}, rsp_resultado, 8'h00);
    chk({tag, "_rsp_flags"}, rsp_flags, 8'h00);
    chk({tag, "_status"}, status_flags, 8'h00);
    chk({tag, "_alu_a"}, alu_a, 8'h00);
    chk({tag, "_alu_b"}, alu_b, 8'h00);
    chk({tag, "_alu_op"}, alu_op, 4'b0000);
  endtask

  // Called just after a falling edge with the DUT in IDLE. Presents pat,
  // expects port g to win, checks n EXEC cycles, the response, that the
  // wrong port's rsp_ready is ignored, then completes the handshake.
  task automatic do_txn(input logic [1:0] pat, input int g, input int n,
                        input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] res, input logic [7:0] flg, input bit hold);
    logic [1:0] gbit;
    gbit = (g == 0) ? 2'b01 : 2'b10;
    req_valid = pat;
    #1;
    chk("req_ready_idle", req_ready, gbit);
    @(negedge clk);
    if (!hold) req_valid = 2'b00;
    for (int k = 0; k < n; k++) begin
      #1;
      chk("busy_exec", busy, 1'b1);
      chk("rsp_valid_exec", rsp_valid, 2'b00);
      chk("req_ready_exec", req_ready, 2'b00);
      chk("alu_op_exec", alu_op, op);
      chk("alu_a_exec", alu_a, a);
      @(negedge clk);
    end
    #1;
    chk("rsp_valid_resp", rsp_valid, gbit);
    chk("rsp_resultado", rsp_resultado, res);
    chk("rsp_flags", rsp_flags, flg);
    chk("status_flags", status_flags, flg);
    chk("busy_resp", busy, 1'b1);
    rsp_ready = ~gbit;
    @(negedge clk);
    #1;
    chk("wrong_port_ready_ignored", rsp_valid, gbit);
    rsp_ready = gbit;
    @(negedge clk);
    #1;
    chk("rsp_valid_after_hs", rsp_valid, 2'b00);
    chk("busy_after_hs", busy, 1'b0);
    chk("hold_result", rsp_resultado, res);
    rsp_ready = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors_applied = 0;
    miscompares     = 0;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_a0 = 8'h00; req_b0 = 8'h00; req_op0 = 4'b0000;
    req_a1 = 8'h00; req_b1 = 8'h00; req_op1 = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Add 0x80+0x80 on port 0.
    req_a0 = 8'h80; req_b0 = 8'h80; req_op0 = 4'b0000;
    do_txn(2'b01, 0, 1, 4'b0000, 8'h80, 8'h00, 8'h62, 1'b0);

    // Sub 0x05-0x03 on port 1.
    req_a1 = 8'h05; req_b1 = 8'h03; req_op1 = 4'b0001;
    do_txn(2'b10, 1, 1, 4'b0001, 8'h05, 8'h02, 8'h10, 1'b0);

    // Mul 0x10*0x10, four EXEC cycles, carry masked.
    req_a0 = 8'h10; req_b0 = 8'h10; req_op0 = 4'b1000;
    do_txn(2'b01, 0, 4, 4'b1000, 8'h10, 8'h00, 8'h40, 1'b0);

    // Div by zero on port 1.
    req_a1 = 8'h07; req_b1 = 8'h00; req_op1 = 4'b1001;
    do_txn(2'b10, 1, 4, 4'b1001, 8'h07, 8'hFF, 8'h80, 1'b0);

    // Unassigned op code: one cycle, 0x00 with Z only.
    req_a0 = 8'h33; req_b0 = 8'h44; req_op0 = 4'b1110;
    do_txn(2'b01, 0, 1, 4'b1110, 8'h33, 8'h00, 8'h40, 1'b0);

    // Both ports request continuously: grants alternate, port 1 first here
    // because port 0 won last.
    req_a0 = 8'h01; req_b0 = 8'h02; req_op0 = 4'b0000;
    req_a1 = 8'h04; req_b1 = 8'h09; req_op1 = 4'b0001;
    for (int j = 0; j < 4; j++) begin
      if ((j % 2) == 0) do_txn(2'b11, 1, 1, 4'b0001, 8'h04, 8'hFB, 8'hB0, 1'b1);
      else              do_txn(2'b11, 0, 1, 4'b0000, 8'h01, 8'h03, 8'h00, 1'b1);
    end
    req_valid = 2'b00;
    // Last commit was port 0 (flags 0x00); run one port-1 op so status is non-zero.
    do_txn(2'b10, 1, 1, 4'b0001, 8'h04, 8'hFB, 8'hB0, 1'b0);

    // Reset mid-EXEC of a divide accepted on port 0.
    req_a0 = 8'h07; req_b0 = 8'h03; req_op0 = 4'b1001;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("busy_before_rst", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset_state("midexec_rst");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk("rsp_valid_in_rst", rsp_valid, 2'b00);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk("no_rsp_dropped_op", rsp_valid, 2'b00);
      chk("idle_after_rst", busy, 1'b0);
    end

    // First tie after reset goes to port 0.
    req_a0 = 8'h03; req_b0 = 8'h04; req_op0 = 4'b0000;
    do_txn(2'b11, 0, 1, 4'b0000, 8'h03, 8'h07, 8'h10, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
